sp_ram_arbiter: RTL and testbench
=================================

Name: sp_ram_arbiter

Overview:
Shares one single-port word RAM (1-cycle read latency) between N_PORTS request/grant masters, such as the instruction or data ports of the replicated cores in the fault-tolerant SoC. It performs round-robin arbitration with at most one access per cycle, and routes each response back to its requester one cycle after grant. Out-of-range and misaligned accesses are answered with an error response and never reach the RAM.

Parameters:
N_PORTS, 2, number of requesters; must be 2 or more.
ADDR_WIDTH, 32, requester byte-address width.
DATA_WIDTH, 32, data width; fixed at 32 (one 4-bit byte enable).
MEM_ADDR_WIDTH, 8, RAM word-address width (256 words).
BASE_ADDR, 32'h0000_0000, byte address of RAM word 0; must be 4-aligned.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
port_req_i  in  N_PORTS  per-port request.
port_gnt_o  out  N_PORTS  per-port grant (combinational, one-hot or zero).
port_addr_i  in  N_PORTS x ADDR_WIDTH  byte address.
port_we_i  in  N_PORTS  1 = write.
port_be_i  in  N_PORTS x 4  byte enables.
port_wdata_i  in  N_PORTS x 32  write data.
port_rvalid_o  out  N_PORTS  response valid.
port_rdata_o  out  N_PORTS x 32  read data.
port_err_o  out  N_PORTS  error, qualified by rvalid.
mem_en_o  out  1  RAM access enable.
mem_we_o  out  1  RAM write enable.
mem_be_o  out  4  RAM byte enables.
mem_addr_o  out  MEM_ADDR_WIDTH  RAM word address.
mem_wdata_o  out  32  RAM write data.
mem_rdata_i  in  32  RAM read data; valid the cycle after mem_en_o.

Behaviour:
- Reset:
  - rr_ptr = 0, resp_valid_q = 0, resp_port_q = 0, resp_err_q = 0, resp_we_q = 0.
  - All port_gnt_o, port_rvalid_o and port_err_o are 0; port_rdata_o are 0.
  - mem_en_o = 0.
- Arbitration (combinational):
  - Scan ports starting at rr_ptr, ascending with wrap-around.
  - Grant the first port with req = 1; at most one gnt bit set per cycle.
  - No requests: no grant and mem_en_o = 0.
- Pointer update on a grant to port k: rr_ptr <= (k+1) mod N_PORTS. With no grant, rr_ptr is held.
- Access check for the granted port:
  - offset = addr - BASE_ADDR (ADDR_WIDTH wrap).
  - ok = (addr[1:0] == 0) AND offset < 4*2^MEM_ADDR_WIDTH.
- ok grant:
  - mem_en_o = 1, mem_we_o = we, mem_be_o = be, mem_wdata_o = wdata.
  - mem_addr_o = offset[MEM_ADDR_WIDTH+1:2].
- Not-ok grant:
  - The request is still granted, but mem_en_o = 0 and mem_we_o = 0.
  - The error is recorded for the response.
- Response (latency exactly 1 cycle after the grant edge):
  - resp_valid_q <= any grant; resp_port_q <= k; resp_err_q <= !ok; resp_we_q <= we.
  - port_rvalid_o[j] = resp_valid_q & (resp_port_q == j).
  - port_err_o[j] = port_rvalid_o[j] & resp_err_q.
  - port_rdata_o[j] = mem_rdata_i if rvalid[j] & !err & !we, else 0.
- Back-to-back operation:
  - A new grant may occur in the same cycle a response is returned, giving full throughput of 1 access/cycle.
  - Responses return in grant order.
- Simultaneous requests: all requesting ports are served in rotating order, with no port starved for more than N_PORTS-1 grants.
- Requester obligations: a requester holds addr/we/be/wdata stable while req = 1 and gnt = 0. A request deasserted before grant is dropped with no side effects.
- Reset mid-operation: a pending response is discarded; rvalid is not asserted after reset release.
- Unused mem_* outputs when mem_en_o = 0: driven to 0.

Decomposition:
- Package soc_mem_pkg holds:
  - localparam WORD_BYTES = 4.
  - A typedef struct mem_req_t {addr, we, be, wdata}.
  - A typedef struct mem_rsp_t {rvalid, rdata, err}.
  - Function addr_in_range(addr, base, mem_addr_width).
- Sub-module rr_arbiter (parameter N) holds rr_ptr and produces a one-hot grant plus a granted-index output. sp_ram_arbiter instantiates it and adds the check, mux and response registers.

Test Plan:
- Single read: port0 reads addr 0x10 with mem[4] = 0xDEADBEEF. gnt0 in the same cycle, mem_addr_o = 4; one cycle later rvalid0 = 1, rdata0 = 0xDEADBEEF, err0 = 0, rvalid1 = 0.
- Write then read-back: port1 writes 0xA5A5A5A5 with be 4'b0011 to 0x20 over an old value of 0xFFFFFFFF. mem_we_o = 1, be = 0011, and a later read returns 0xFFFFA5A5.
- Contention: both ports request continuously for 6 cycles starting from reset (rr_ptr = 0). Grants are 0,1,0,1,0,1 and responses route to the matching port one cycle after each grant.
- Errors: read at 0x400 (out of range for 256 words), then write to 0x13 (misaligned). Each is granted with mem_en_o = 0, followed next cycle by rvalid = 1, err = 1, rdata = 0.
- Idle pointer hold: port1 is granted, then 3 idle cycles, then both ports request. Port0 is granted first (rr_ptr = 0 is held through the idle cycles).
- Reset mid-access: assert rst_ni = 0 asynchronously right after a granted read. There is no rvalid on any port after release, and the next simultaneous request is granted to port0.

Source files
------------

// File: rtl/soc_mem_pkg.sv
// rtl/soc_mem_pkg.sv - shared request/response types and address window check
package soc_mem_pkg;

  localparam int WORD_BYTES     = 4;
  localparam int MAX_ADDR_WIDTH = 64;

  typedef struct packed {
    logic [MAX_ADDR_WIDTH-1:0] addr;
    logic                      we;
    logic [WORD_BYTES-1:0]     be;
    logic [31:0]               wdata;
  } mem_req_t;

  typedef struct packed {
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } mem_rsp_t;

  // Word-aligned and inside [base, base + WORD_BYTES * 2^mem_addr_width),
  // with the subtraction wrapping at addr_width bits.
  function automatic logic addr_in_range(input logic [MAX_ADDR_WIDTH-1:0] addr,
                                         input logic [MAX_ADDR_WIDTH-1:0] base,
                                         input int unsigned addr_width,
                                         input int unsigned mem_addr_width);
    logic [MAX_ADDR_WIDTH-1:0] mask;
    logic [MAX_ADDR_WIDTH-1:0] offset;
    logic [MAX_ADDR_WIDTH-1:0] limit;
    mask   = (addr_width >= MAX_ADDR_WIDTH) ? '1 : ((64'd1 << addr_width) - 64'd1);
    offset = (addr - base) & mask;
    limit  = 64'(WORD_BYTES) << mem_addr_width;
    return (addr[1:0] == 2'b00) && (offset < limit);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with one-hot grant and granted index
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] rr_ptr_d;
  int            cand_int;
  logic [IW-1:0] cand;

  // Scan upward from the pointer with wrap-around; first requester wins
  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand_int = 0;
    cand     = '0;
    for (int i = 0; i < N; i++) begin
      cand_int = int'(rr_ptr_q) + i;
      if (cand_int >= N) cand_int = cand_int - N;
      cand = IW'(cand_int);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

  // Next pointer: one past the winner, held when nobody is granted
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (valid_o) begin
      rr_ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  // Pointer register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// rtl/sp_ram_arbiter.sv - shares one single-port word RAM between N request/grant ports
module sp_ram_arbiter
  import soc_mem_pkg::*;
#(
  parameter int N_PORTS        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [N_PORTS-1:0]                    port_req_i,
  output logic [N_PORTS-1:0]                    port_gnt_o,
  input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]    port_addr_i,
  input  logic [N_PORTS-1:0]                    port_we_i,
  input  logic [N_PORTS-1:0][WORD_BYTES-1:0]    port_be_i,
  input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]    port_wdata_i,
  output logic [N_PORTS-1:0]                    port_rvalid_o,
  output logic [N_PORTS-1:0][DATA_WIDTH-1:0]    port_rdata_o,
  output logic [N_PORTS-1:0]                    port_err_o,
  output logic                                  mem_en_o,
  output logic                                  mem_we_o,
  output logic [WORD_BYTES-1:0]                 mem_be_o,
  output logic [MEM_ADDR_WIDTH-1:0]             mem_addr_o,
  output logic [DATA_WIDTH-1:0]                 mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata_i
);

  localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [N_PORTS-1:0]    gnt;
  logic [IW-1:0]         gnt_idx;
  logic                  gnt_any;
  mem_req_t              sel_req;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  access_ok;

  logic                  resp_valid_q, resp_valid_d;
  logic [IW-1:0]         resp_port_q,  resp_port_d;
  logic                  resp_err_q,   resp_err_d;
  logic                  resp_we_q,    resp_we_d;

  mem_rsp_t              rsp [N_PORTS];

  rr_arbiter #(.N(N_PORTS)) u_rr_arbiter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (port_req_i),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (gnt_any)
  );

  assign port_gnt_o = gnt;

  // Pick the granted port's request and check it against the RAM window
  always_comb begin
    sel_req.addr  = MAX_ADDR_WIDTH'(port_addr_i[gnt_idx]);
    sel_req.we    = port_we_i[gnt_idx];
    sel_req.be    = port_be_i[gnt_idx];
    sel_req.wdata = port_wdata_i[gnt_idx];
    offset        = port_addr_i[gnt_idx] - BASE_ADDR;
    access_ok     = gnt_any && addr_in_range(sel_req.addr, MAX_ADDR_WIDTH'(BASE_ADDR),
                                             ADDR_WIDTH, MEM_ADDR_WIDTH);
  end

  // Drive the RAM only for legal accesses; everything else stays at zero
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (access_ok) begin
      mem_en_o    = 1'b1;
      mem_we_o    = sel_req.we;
      mem_be_o    = sel_req.be;
      mem_addr_o  = MEM_ADDR_WIDTH'(offset >> 2);
      mem_wdata_o = sel_req.wdata;
    end
  end

  // Capture who was granted and how, so the reply lines up with RAM read data
  always_comb begin
    resp_valid_d = gnt_any;
    resp_port_d  = gnt_idx;
    resp_err_d   = gnt_any && !access_ok;
    resp_we_d    = sel_req.we;
  end

  // Response registers; reset drops any reply still in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_q <= 1'b0;
      resp_port_q  <= '0;
      resp_err_q   <= 1'b0;
      resp_we_q    <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_port_q  <= resp_port_d;
      resp_err_q   <= resp_err_d;
      resp_we_q    <= resp_we_d;
    end
  end

  // Route the reply to its port; read data only for successful reads
  always_comb begin
    for (int j = 0; j < N_PORTS; j++) begin
      rsp[j].rvalid    = resp_valid_q && (resp_port_q == IW'(j));
      rsp[j].err       = rsp[j].rvalid && resp_err_q;
      rsp[j].rdata     = (rsp[j].rvalid && !resp_err_q && !resp_we_q) ? mem_rdata_i : '0;
      port_rvalid_o[j] = rsp[j].rvalid;
      port_err_o[j]    = rsp[j].err;
      port_rdata_o[j]  = rsp[j].rdata;
    end
  end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb/tb_sp_ram_arbiter.sv - scoreboard bench for sp_ram_arbiter with a behavioural RAM model
module tb_sp_ram_arbiter;

  localparam int NP  = 2;
  localparam int AW  = 32;
  localparam int MAW = 8;
  localparam logic [AW-1:0] BASE = 32'h0000_0000;
  localparam int WORDS = 1 << MAW;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;

  logic [NP-1:0]          req, gnt, we, rvalid, err;
  logic [NP-1:0][AW-1:0]  addr;
  logic [NP-1:0][3:0]     be;
  logic [NP-1:0][31:0]    wdata, rdata;
  logic                   mem_en, mem_we;
  logic [3:0]             mem_be;
  logic [MAW-1:0]         mem_addr;
  logic [31:0]            mem_wdata;
  logic [31:0]            mem_rdata = 32'h0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] ram     [WORDS];
  logic [31:0] ref_mem [WORDS];

  typedef struct {
    int          due;
    int          port;
    bit          err;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  int            m_ptr = 0;
  logic [NP-1:0] gnt_seen = '0;

  sp_ram_arbiter #(
    .N_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(32), .MEM_ADDR_WIDTH(MAW), .BASE_ADDR(BASE)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .port_req_i(req), .port_gnt_o(gnt), .port_addr_i(addr), .port_we_i(we),
    .port_be_i(be), .port_wdata_i(wdata),
    .port_rvalid_o(rvalid), .port_rdata_o(rdata), .port_err_o(err),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM with one-cycle read latency, driven by the DUT's mem bus
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: decides the grant from the rotation rule, checks the
  // grant and RAM bus, and queues the reply the requester should receive.
  int          k, p;
  logic [AW-1:0] off;
  bit          ok;
  logic [31:0] rd;
  always @(negedge clk) begin
    if (rst_ni !== 1'b1) begin
      m_ptr    = 0;
      gnt_seen = '0;
    end else begin
      k = -1;
      for (int i = 0; i < NP; i++) begin
        p = (m_ptr + i) % NP;
        if (k < 0 && req[p]) k = p;
      end
      gnt_seen = gnt;
      if (k < 0) begin
        chk("gnt_idle", 64'(gnt), 64'd0);
        chk("mem_bus_idle", {mem_en, mem_we, mem_be, mem_addr, mem_wdata}, 64'd0);
      end else begin
        chk("gnt", 64'(gnt), 64'd1 << k);
        off = addr[k] - BASE;
        ok  = (addr[k] % 4 == 0) && (off < 32'(4 * WORDS));
        if (ok)
          chk("mem_bus", {mem_en, mem_we, mem_be, mem_addr, mem_wdata},
              {1'b1, we[k], be[k], MAW'(off / 4), wdata[k]});
        else
          chk("mem_bus_err", {mem_en, mem_we, mem_be, mem_addr, mem_wdata}, 64'd0);
        rd = (ok && !we[k]) ? ref_mem[off / 4] : 32'h0;
        if (ok && we[k])
          for (int b = 0; b < 4; b++)
            if (be[k][b]) ref_mem[off / 4][8*b +: 8] = wdata[k][8*b +: 8];
        exp_q.push_back('{cyc + 1, k, !ok, rd});
        m_ptr = (k + 1) % NP;
      end
    end
  end

  // Monitor: every cycle the reply lines must match the oldest due entry
  logic [NP-1:0]       e_v, e_e;
  logic [NP-1:0][31:0] e_d;
  always @(negedge clk) begin
    e_v = '0; e_e = '0; e_d = '0;
    if (rst_ni !== 1'b1) begin
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e_v[exp_q[0].port] = 1'b1;
      e_e[exp_q[0].port] = exp_q[0].err;
      e_d[exp_q[0].port] = exp_q[0].rdata;
      void'(exp_q.pop_front());
    end
    chk("rvalid", 64'(rvalid), 64'(e_v));
    chk("err", 64'(err), 64'(e_e));
    chk("rdata", 64'(rdata), 64'(e_d));
  end

  task automatic access(input int pt, input logic [31:0] a, input bit w,
                        input logic [3:0] b, input logic [31:0] d);
    int n;
    req[pt] = 1'b1; addr[pt] = a; we[pt] = w; be[pt] = b; wdata[pt] = d;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!gnt_seen[pt] && n < 50);
    if (!gnt_seen[pt]) begin
      errors++;
      checks++;
      $display("FAIL grant_timeout: port %0d not granted within 50 cycles", pt);
    end
    @(posedge clk); #1;
    req[pt] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle(3);
    rst_ni = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8)       return 32'($urandom_range(0, 15) * 4);
    else if (r == 8) return 32'h400 + ($urandom & 32'h0000_FFFC);
    else             return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
  endfunction

  task automatic new_req(input int pt);
    req[pt]   = 1'b1;
    addr[pt]  = rand_addr();
    we[pt]    = 1'($urandom_range(0, 1));
    be[pt]    = 4'($urandom);
    wdata[pt] = $urandom;
  endtask

  initial begin
    req = '0; addr = '0; we = '0; be = '0; wdata = '0;
    for (int i = 0; i < WORDS; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;

    // Single read after preload, then masked write over an all-ones word
    access(1, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF);
    access(0, 32'h10, 1'b0, 4'hF, 32'h0);
    access(0, 32'h20, 1'b1, 4'hF, 32'hFFFFFFFF);
    access(1, 32'h20, 1'b1, 4'b0011, 32'hA5A5A5A5);
    access(0, 32'h20, 1'b0, 4'hF, 32'h0);
    idle(1);

    // Error responses: out of range read, misaligned write
    access(0, 32'h400, 1'b0, 4'hF, 32'h0);
    access(1, 32'h13, 1'b1, 4'hF, 32'h12345678);
    access(0, 32'h3FC, 1'b0, 4'hF, 32'h0);
    idle(1);

    // Contention straight out of reset
    do_reset();
    for (int pt = 0; pt < NP; pt++) begin
      req[pt] = 1'b1; addr[pt] = 32'(pt * 4 + 8); we[pt] = 1'b0; be[pt] = 4'hF;
    end
    idle(6);
    req = '0;
    idle(1);

    // Pointer held across idle cycles
    do_reset();
    access(1, 32'h4, 1'b0, 4'hF, 32'h0);
    idle(3);
    req = '1; addr[0] = 32'h8; addr[1] = 32'hC; we = '0;
    idle(2);
    req = '0;
    idle(1);

    // Reset while a read reply is in flight
    access(0, 32'h10, 1'b0, 4'hF, 32'h0);
    do_reset();
    req = '1; addr[0] = 32'h14; addr[1] = 32'h18; we = '0;
    idle(2);
    req = '0;
    idle(1);

    // Randomized traffic, including requests withdrawn before grant
    for (int c = 0; c < 1500; c++) begin
      for (int pt = 0; pt < NP; pt++) begin
        if (req[pt] && gnt_seen[pt]) begin
          if ($urandom_range(0, 9) < 7) new_req(pt);
          else req[pt] = 1'b0;
        end else if (req[pt]) begin
          if ($urandom_range(0, 19) == 0) req[pt] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          new_req(pt);
        end
      end
      idle(1);
    end
    req = '0;
    idle(4);
    chk("replies_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
